// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       signal_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q != ^shift_q;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= signal_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx: frames, back-to-back, errors, glitch, mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int ParExtra = Cpb;
`else
  localparam int ParExtra = 0;
`endif

  typedef struct packed {
    logic [1:0] kind;  // 0 valid, 1 frame error, 2 parity error
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, parity_err;

  exp_t       sb[$];
  int         valid_cycs[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_data = 8'h00;

  uart_rx #(.CLKS_PER_BIT(Cpb), .CNT_W(16)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .signal_i     (signal),
    .data_o       (data),
    .valid_o      (valid),
    .busy_o       (busy),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Pops the scoreboard whenever the DUT emits any pulse.
  task automatic monitor();
    exp_t       e;
    logic [1:0] k;
    if (valid || frame_err || parity_err) begin
      chk("one_hot_pulse", 32'($countones({valid, frame_err, parity_err})), 32'd1);
      k = valid ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
      if (valid) valid_cycs.push_back(cyc);
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_pulse: observed kind %0d data %0h expected no pulse", k, data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(k), 32'(e.kind));
        chk("pulse_data", 32'(data), 32'(e.data));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #0.5;
    cyc++;
    monitor();
  endtask

  task automatic hold(input logic b, input int n);
    signal = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    if (!stop) begin
      e = '{kind: 2'd1, data: model_data};
`ifdef UART_RX_PARITY_EN
    end else if (par != ^d) begin
      e = '{kind: 2'd2, data: model_data};
`endif
    end else begin
      model_data = d;
      e = '{kind: 2'd0, data: d};
    end
    sb.push_back(e);
    hold(1'b0, Cpb);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) hold(d[i], Cpb);
`ifdef UART_RX_PARITY_EN
    hold(par, Cpb);
`endif
    hold(stop, Cpb);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int t0;
    // Reset hold
    rst_n  = 1'b0;
    signal = 1'b1;
    repeat (5) tick();
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({valid, frame_err, parity_err}), 32'd0);
    rst_n = 1'b1;
    repeat (500) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_data", 32'(data), 32'h00);

    // Basic frame with latency check
    t0 = cyc;
    valid_cycs.delete();
    send_frame(8'hAA, 1'b1, 1'b0);
    drain(40);
    chk("basic_data", 32'(data), 32'hAA);
    chk("basic_count", 32'(valid_cycs.size()), 32'd1);
    if (valid_cycs.size() > 0)
      chk_range("basic_latency", valid_cycs[0] - t0, 153 + ParExtra, 156 + ParExtra);
    hold(1'b1, 20);

    // Loopback-style frame as a transmitter would drive it
    send_frame(8'h55, 1'b1, 1'b0);
    drain(40);
    chk("loop_data", 32'(data), 32'h55);
    hold(1'b1, 20);

    // Back-to-back frames with no idle gap
    valid_cycs.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain(40);
    chk("b2b_count", 32'(valid_cycs.size()), 32'd2);
    if (valid_cycs.size() == 2)
      chk("b2b_spacing", 32'(valid_cycs[1] - valid_cycs[0]), 32'(10 * Cpb + ParExtra));
    chk("b2b_data", 32'(data), 32'hFF);
    hold(1'b1, 20);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 50);
    chk("ferr_drained", 32'(sb.size()), 32'd0);
    chk("break_busy", 32'(busy), 32'd1);
    chk("ferr_data", 32'(data), 32'hFF);
    hold(1'b1, 6);
    chk("break_exit", 32'(busy), 32'd0);

    // Short glitch on an idle line
    hold(1'b0, 4);
    hold(1'b1, 20);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_data", 32'(data), 32'hFF);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drain(40);
    chk("par_ok_data", 32'(data), 32'h07);
    hold(1'b1, 20);
    send_frame(8'h07, 1'b1, 1'b0);
    drain(40);
    chk("par_bad_data", 32'(data), 32'h07);
    hold(1'b1, 20);
`endif

    // Reset during data bit 4 aborts the frame silently
    hold(1'b0, Cpb);
    for (int i = 0; i < 4; i++) hold(1'(i % 2), Cpb);
    hold(1'b0, Cpb / 2);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pulses", 32'({valid, frame_err, parity_err}), 32'd0);
    model_data = 8'h00;
    rst_n = 1'b1;
    hold(1'b1, 40);
    chk("post_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    drain(40);
    chk("post_rst_data", 32'(data), 32'h81);
    hold(1'b1, 20);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
